// File: rtl/tl_pkg.sv
// Shared state encodings, lamp patterns and default phase durations for the
// two-way intersection phase controller.
package tl_pkg;

    typedef enum logic [2:0] {
        AR_NS = 3'd0,
        NS_G  = 3'd1,
        NS_Y  = 3'd2,
        AR_EW = 3'd3,
        EW_G  = 3'd4,
        EW_Y  = 3'd5,
        FLASH = 3'd6
    } tl_state_t;

    // Lamp drives are {red, yellow, green}
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [2:0] OFF = 3'b000;

    localparam int DEF_GREEN_TIME  = 9;
    localparam int DEF_YELLOW_TIME = 3;
    localparam int DEF_ALLRED_TIME = 1;
    localparam int DEF_PED_CUT     = 3;

endpackage

// File: rtl/phase_timer.sv
// 4-bit phase down-counter: load has priority, then the pedestrian cut,
// then a tick-enabled decrement that holds at zero.
module phase_timer #(
    parameter logic [3:0] RESET_VALUE = 4'd1
) (
    input  logic       clk,
    input  logic       srst,
    input  logic       tick,
    input  logic       load,
    input  logic [3:0] load_value,
    input  logic       cut,
    input  logic [3:0] cut_value,
    output logic [3:0] count,
    output logic       zero
);

    logic [3:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= RESET_VALUE;
        end else if (load) begin
            count_reg <= load_value;
        end else if (tick && cut) begin
            count_reg <= cut_value;
        end else if (tick && (count_reg != 4'd0)) begin
            count_reg <= count_reg - 4'd1;
        end
    end

    assign count = count_reg;
    assign zero  = (count_reg == 4'd0);

endmodule

// File: rtl/traffic_phase_controller.sv
// Intersection phase FSM with pedestrian green cut and night flashing mode;
// drives both roads' lamps and the 0-9 countdown for the digit decoder.
module traffic_phase_controller
    import tl_pkg::*;
#(
    parameter int GREEN_TIME  = DEF_GREEN_TIME,
    parameter int YELLOW_TIME = DEF_YELLOW_TIME,
    parameter int ALLRED_TIME = DEF_ALLRED_TIME,
    parameter int PED_CUT     = DEF_PED_CUT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       night_mode,
    input  logic       ped_req,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic [3:0] time_remaining,
    output logic [2:0] state
);

    tl_state_t  state_reg, state_next;
    logic       ped_pending_reg, ped_pending_next;
    logic       flash_phase_reg, flash_phase_next;
    logic       timer_load, timer_cut, timer_zero;
    logic [3:0] timer_load_value;
    logic [3:0] timer_count;
    logic       ped_effective;
    logic       in_green;

    phase_timer #(
        .RESET_VALUE(4'(ALLRED_TIME))
    ) u_phase_timer (
        .clk        (clk),
        .srst       (rst),
        .tick       (tick),
        .load       (timer_load),
        .load_value (timer_load_value),
        .cut        (timer_cut),
        .cut_value  (4'(PED_CUT)),
        .count      (timer_count),
        .zero       (timer_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= AR_NS;
            ped_pending_reg <= 1'b0;
            flash_phase_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            ped_pending_reg <= ped_pending_next;
            flash_phase_reg <= flash_phase_next;
        end
    end

    assign ped_effective = ped_pending_reg | ped_req;
    assign in_green      = (state_reg == NS_G) || (state_reg == EW_G);

    always_comb begin
        state_next       = state_reg;
        ped_pending_next = ped_effective;
        flash_phase_next = flash_phase_reg;
        timer_load       = 1'b0;
        timer_load_value = 4'd0;
        timer_cut        = 1'b0;

        if (state_reg == FLASH) begin
            // Pedestrian requests are meaningless while flashing
            ped_pending_next = 1'b0;
            if (!night_mode) begin
                state_next       = AR_NS;
                timer_load       = 1'b1;
                timer_load_value = 4'(ALLRED_TIME);
                flash_phase_next = 1'b0;
            end else if (tick) begin
                flash_phase_next = ~flash_phase_reg;
            end
        end else if (night_mode) begin
            state_next       = FLASH;
            timer_load       = 1'b1;
            timer_load_value = 4'd0;
            flash_phase_next = 1'b0;
            ped_pending_next = 1'b0;
        end else begin
            case (state_reg)
                AR_NS, NS_G, NS_Y, AR_EW, EW_G, EW_Y: begin
                    if (tick && timer_zero) begin
                        timer_load = 1'b1;
                        if (in_green) ped_pending_next = 1'b0;
                        case (state_reg)
                            AR_NS:   begin state_next = NS_G;  timer_load_value = 4'(GREEN_TIME);  end
                            NS_G:    begin state_next = NS_Y;  timer_load_value = 4'(YELLOW_TIME); end
                            NS_Y:    begin state_next = AR_EW; timer_load_value = 4'(ALLRED_TIME); end
                            AR_EW:   begin state_next = EW_G;  timer_load_value = 4'(GREEN_TIME);  end
                            EW_G:    begin state_next = EW_Y;  timer_load_value = 4'(YELLOW_TIME); end
                            default: begin state_next = AR_NS; timer_load_value = 4'(ALLRED_TIME); end
                        endcase
                    end else if (tick && in_green && ped_effective
                                 && (timer_count > 4'(PED_CUT))) begin
                        timer_cut = 1'b1;
                    end
                end
                default: begin
                    // Unused encoding: restart the cycle from the NS all-red
                    state_next       = AR_NS;
                    timer_load       = 1'b1;
                    timer_load_value = 4'(ALLRED_TIME);
                    ped_pending_next = 1'b0;
                    flash_phase_next = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        ns_light = RED;
        ew_light = RED;
        case (state_reg)
            NS_G:    ns_light = GRN;
            NS_Y:    ns_light = YEL;
            EW_G:    ew_light = GRN;
            EW_Y:    ew_light = YEL;
            FLASH: begin
                ns_light = {1'b0, flash_phase_reg, 1'b0};
                ew_light = {1'b0, flash_phase_reg, 1'b0};
            end
            default: begin
                ns_light = RED;
                ew_light = RED;
            end
        endcase
    end

    assign time_remaining = timer_count;
    assign state          = state_reg;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Scenario bench for traffic_phase_controller: a behavioural model queues the
// expected outputs for every driven cycle; each scenario pops and compares.
module tb_traffic_phase_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       night_mode = 1'b0;
    logic       ped_req = 1'b0;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic [3:0] time_remaining;
    logic [2:0] state;

    always #5 clk = ~clk;

    traffic_phase_controller dut (
        .clk            (clk),
        .rst            (rst),
        .tick           (tick),
        .night_mode     (night_mode),
        .ped_req        (ped_req),
        .ns_light       (ns_light),
        .ew_light       (ew_light),
        .time_remaining (time_remaining),
        .state          (state)
    );

    typedef struct packed {
        logic [2:0] st;
        logic [3:0] tr;
        logic [2:0] ns;
        logic [2:0] ew;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model state
    int m_st, m_tr;
    bit m_ped, m_fp;
    int dur[6] = '{1, 9, 3, 1, 9, 3};

    function automatic obs_t model_obs();
        obs_t o;
        o.st = 3'(m_st);
        o.tr = 4'(m_tr);
        o.ns = 3'b100;
        o.ew = 3'b100;
        if (m_st == 1) o.ns = 3'b001;
        if (m_st == 2) o.ns = 3'b010;
        if (m_st == 4) o.ew = 3'b001;
        if (m_st == 5) o.ew = 3'b010;
        if (m_st == 6) begin
            o.ns = {1'b0, m_fp, 1'b0};
            o.ew = {1'b0, m_fp, 1'b0};
        end
        return o;
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o.st = state;
        o.tr = time_remaining;
        o.ns = ns_light;
        o.ew = ew_light;
        return o;
    endfunction

    // Apply one clock of stimulus, advance the model and queue its prediction
    task automatic drive(input bit r, input bit t, input bit n, input bit p);
        bit eff, green;
        rst = r; tick = t; night_mode = n; ped_req = p;
        if (r) begin
            m_st = 0; m_tr = 1; m_ped = 0; m_fp = 0;
        end else if (m_st == 6) begin
            m_ped = 0;
            if (!n) begin
                m_st = 0; m_tr = 1; m_fp = 0;
            end else if (t) begin
                m_fp = !m_fp;
            end
        end else if (n) begin
            m_st = 6; m_tr = 0; m_fp = 0; m_ped = 0;
        end else begin
            eff   = m_ped | p;
            green = (m_st == 1) || (m_st == 4);
            m_ped = eff;
            if (t) begin
                if (m_tr == 0) begin
                    if (green) m_ped = 0;
                    m_st = (m_st + 1) % 6;
                    m_tr = dur[m_st];
                end else if (green && eff && m_tr > 3) begin
                    m_tr = 3;
                end else begin
                    m_tr = m_tr - 1;
                end
            end
        end
        exp_q.push_back(model_obs());
        @(posedge clk);
        #1;
        rst = 1'b0; tick = 1'b0; night_mode = 1'b0; ped_req = 1'b0;
    endtask

    task automatic test_reset();
        obs_t e, g;
        drive(1, 1, 0, 1);
        e = exp_q.pop_front(); g = dut_obs(); checks++;
        if (g !== e) begin
            failures++;
            $display("FAIL reset got=%h expected=%h", g, e);
        end
        checks++;
        if (dut.ped_pending_reg !== 1'b0) begin
            failures++;
            $display("FAIL reset_ped_pending got=%b expected=0", dut.ped_pending_reg);
        end
    endtask

    task automatic test_first_ticks();
        obs_t e, g;
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 0, 0);
            e = exp_q.pop_front(); g = dut_obs(); checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL first_ticks[%0d] got=%h expected=%h", i, g, e);
            end
        end
        checks++;
        if ({state, time_remaining, ns_light, ew_light} !== {3'd1, 4'd9, 3'b001, 3'b100}) begin
            failures++;
            $display("FAIL first_ticks_ns_green got st=%0d tr=%0d ns=%b ew=%b expected st=1 tr=9 ns=001 ew=100",
                     state, time_remaining, ns_light, ew_light);
        end
    endtask

    task automatic test_full_cycle();
        obs_t e, g;
        drive(1, 0, 0, 0);
        void'(exp_q.pop_front());
        for (int i = 0; i < 32; i++) begin
            drive(0, 1, 0, 0);
            e = exp_q.pop_front(); g = dut_obs(); checks++;
            if (g !== e || time_remaining > 4'd9) begin
                failures++;
                $display("FAIL full_cycle[%0d] got=%h expected=%h", i, g, e);
            end
        end
        checks++;
        if (state !== 3'd0 || time_remaining !== 4'd1) begin
            failures++;
            $display("FAIL full_cycle_return got st=%0d tr=%0d expected st=0 tr=1", state, time_remaining);
        end
    endtask

    task automatic test_ped_cut();
        obs_t e, g;
        drive(1, 0, 0, 0);
        void'(exp_q.pop_front());
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 0);
            void'(exp_q.pop_front());
        end
        drive(0, 0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) drive(0, 1, 0, 0);
            e = exp_q.pop_front(); g = dut_obs(); checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL ped_cut[%0d] got=%h expected=%h", i, g, e);
            end
            if (i == 1) begin
                checks++;
                if (time_remaining !== 4'd3) begin
                    failures++;
                    $display("FAIL ped_cut_value got=%0d expected=3", time_remaining);
                end
            end
        end
        checks++;
        if (state !== 3'd2 || dut.ped_pending_reg !== 1'b0) begin
            failures++;
            $display("FAIL ped_cut_exit got st=%0d pend=%b expected st=2 pend=0", state, dut.ped_pending_reg);
        end
    endtask

    task automatic test_ped_late_and_held();
        obs_t e, g;
        int guard;
        drive(1, 0, 0, 0);
        void'(exp_q.pop_front());
        for (int i = 0; i < 9; i++) begin
            drive(0, 1, 0, 0);
            void'(exp_q.pop_front());
        end
        drive(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) drive(0, 1, 0, 0);
            e = exp_q.pop_front(); g = dut_obs(); checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL ped_late[%0d] got=%h expected=%h", i, g, e);
            end
        end
        // Now in NS_Y: request is held through yellow and all-red
        drive(0, 0, 0, 1);
        void'(exp_q.pop_front());
        guard = 0;
        while (m_st != 4 && guard < 12) begin
            drive(0, 1, 0, 0);
            e = exp_q.pop_front(); g = dut_obs(); checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL ped_held[%0d] got=%h expected=%h", guard, g, e);
            end
            guard++;
        end
        drive(0, 1, 0, 0);
        e = exp_q.pop_front(); g = dut_obs(); checks++;
        if (g !== e || state !== 3'd4 || time_remaining !== 4'd3) begin
            failures++;
            $display("FAIL ped_held_cut got st=%0d tr=%0d expected st=4 tr=3", state, time_remaining);
        end
    endtask

    task automatic test_night();
        obs_t e, g;
        drive(1, 0, 0, 0);
        void'(exp_q.pop_front());
        for (int i = 0; i < 22; i++) begin
            drive(0, 1, 0, 0);
            void'(exp_q.pop_front());
        end
        checks++;
        if (state !== 3'd4 || time_remaining !== 4'd5) begin
            failures++;
            $display("FAIL night_setup got st=%0d tr=%0d expected st=4 tr=5", state, time_remaining);
        end
        drive(0, 0, 1, 0);
        e = exp_q.pop_front(); g = dut_obs(); checks++;
        if (g !== e || {state, time_remaining, ns_light, ew_light} !== {3'd6, 4'd0, 3'b000, 3'b000}) begin
            failures++;
            $display("FAIL night_enter got=%h expected=%h", g, e);
        end
        for (int i = 0; i < 5; i++) begin
            drive(0, (i != 2), 1, 1);
            e = exp_q.pop_front(); g = dut_obs(); checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL night_flash[%0d] got=%h expected=%h", i, g, e);
            end
        end
        drive(0, 0, 0, 0);
        e = exp_q.pop_front(); g = dut_obs(); checks++;
        if (g !== e || {state, time_remaining, ns_light, ew_light} !== {3'd0, 4'd1, 3'b100, 3'b100}) begin
            failures++;
            $display("FAIL night_exit got=%h expected=%h", g, e);
        end
    endtask

    task automatic test_rst_tick();
        obs_t e, g;
        drive(1, 0, 0, 0);
        void'(exp_q.pop_front());
        for (int i = 0; i < 13; i++) begin
            drive(0, 1, 0, 0);
            void'(exp_q.pop_front());
        end
        drive(0, 0, 0, 1);
        void'(exp_q.pop_front());
        drive(1, 1, 0, 1);
        e = exp_q.pop_front(); g = dut_obs(); checks++;
        if (g !== e || dut.ped_pending_reg !== 1'b0) begin
            failures++;
            $display("FAIL rst_tick got=%h pend=%b expected=%h pend=0", g, dut.ped_pending_reg, e);
        end
    endtask

    task automatic test_back_to_back();
        obs_t e, g;
        bit t, n, p;
        drive(1, 0, 0, 0);
        void'(exp_q.pop_front());
        for (int i = 0; i < 300; i++) begin
            t = ($urandom_range(0, 3) != 0);
            n = ($urandom_range(0, 19) == 0) || (m_st == 6 && $urandom_range(0, 3) != 0);
            p = ($urandom_range(0, 9) == 0);
            drive(0, t, n, p);
            e = exp_q.pop_front(); g = dut_obs(); checks++;
            if (g !== e || time_remaining > 4'd9) begin
                failures++;
                $display("FAIL back_to_back[%0d] got=%h expected=%h", i, g, e);
            end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_first_ticks();
        test_full_cycle();
        test_ped_cut();
        test_ped_late_and_held();
        test_night();
        test_rst_tick();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/traffic_phase_controller.md
Name: traffic_phase_controller

Overview:
- Upstream stage that produces the 4-bit countdown value consumed by the intersection's seven-segment digit decoder.
- Sequences a two-way intersection (north-south / east-west) through green, yellow and all-red phases, counting down once per 1 Hz tick.
- Also provides a pedestrian-request green cut and a night flashing-yellow mode.
- Outputs are the lamp drives for both roads, the remaining time (always 0-9), and the current state.

Parameters:
- GREEN_TIME, 9: load value for a green phase; phase lasts GREEN_TIME+1 ticks (legal 1-9).
- YELLOW_TIME, 3: load value for a yellow phase (legal 0-9).
- ALLRED_TIME, 1: load value for an all-red phase (legal 0-9).
- PED_CUT, 3: green is truncated to this count on a pedestrian request (legal 0 to GREEN_TIME-1).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  one-clk-wide 1 Hz enable from the prescaler; held high means one count per clk.
- night_mode  in  1  level; selects flashing mode.
- ped_req  in  1  pedestrian button, one clk or longer.
- ns_light  out  3  {red,yellow,green} for north-south.
- ew_light  out  3  {red,yellow,green} for east-west.
- time_remaining  out  4  countdown value, 0-9, registered.
- state  out  3  current phase encoding.

Behaviour:
- States and encodings:
  - AR_NS = 0 (all-red before NS green)
  - NS_G = 1
  - NS_Y = 2
  - AR_EW = 3
  - EW_G = 4
  - EW_Y = 5
  - FLASH = 6
- Reset (rst high at a clk edge, regardless of tick or any other input):
  - state = AR_NS, time_remaining = ALLRED_TIME, ped_pending = 0, flash_phase = 0.
  - ns_light = ew_light = 3'b100.
- Normal cycle: AR_NS -> NS_G -> NS_Y -> AR_EW -> EW_G -> EW_Y -> AR_NS.
- On a tick:
  - If time_remaining == 0, advance to the next state and load its parameter.
  - Otherwise decrement by 1.
  - Nothing changes without a tick.
- Lamp decode (Moore, from state and flash_phase only):
  - NS_G: ns = 001, ew = 100.
  - NS_Y: ns = 010, ew = 100.
  - EW_G: ns = 100, ew = 001.
  - EW_Y: ns = 100, ew = 010.
  - AR_*: both 100.
  - FLASH: both = {1'b0, flash_phase, 1'b0}.
- Pedestrian handling:
  - ped_pending is set on any cycle with ped_req.
  - Effective request = ped_pending | ped_req.
  - On a tick in NS_G or EW_G with an effective request and time_remaining > PED_CUT: time_remaining loads PED_CUT instead of decrementing.
  - If time_remaining <= PED_CUT, the phase counts down normally.
  - ped_pending clears when a green phase exits to yellow.
  - A request made during yellow or all-red is held for the next green.
- Night mode (priority over tick and ped):
  - night_mode high at a clk edge in any non-FLASH state: next state = FLASH, time_remaining = 0, flash_phase = 0, ped_pending = 0.
  - In FLASH: flash_phase toggles on each tick; ped_req is ignored.
  - night_mode low while in FLASH: next clk goes to AR_NS, time_remaining = ALLRED_TIME.
- Width rules: time_remaining never exceeds 9 and never underflows, because the 0 check precedes the decrement.
- Illegal state encoding 7: recovers to AR_NS with time_remaining = ALLRED_TIME on the next clk.

Decomposition:
- Package tl_pkg:
  - state enum / localparams.
  - Lamp encodings RED = 3'b100, YEL = 3'b010, GRN = 3'b001, OFF = 3'b000.
  - Default duration constants.
- One natural sub-module, phase_timer: 4-bit down-counter with tick enable, load, load_value, cut, and a zero flag.
- The FSM and lamp decode stay in the top module.

Test Plan:
- Reset then 2 ticks:
  - state 0, tr 1 -> tr 0 -> state NS_G, tr 9, ns 001, ew 100.
- tick held high with defaults:
  - Full cycle returns to AR_NS after 32 clks (NS_G 10, NS_Y 4, AR_EW 2, EW_G 10, EW_Y 4, AR_NS 2).
  - time_remaining never > 9.
- ped_req pulse in NS_G at tr 7:
  - Next tick tr 3, then 2, 1, 0, then NS_Y.
  - ped_pending = 0 on entry to NS_Y.
- ped_req pulse in NS_G at tr 2:
  - No cut; normal 1, 0, NS_Y.
- ped_req during NS_Y:
  - Held through AR_EW.
  - First tick in EW_G jumps tr 9 -> 3.
- night_mode raised mid EW_G (tr 5):
  - Next clk FLASH, tr 0, lamps 000.
  - Yellow toggles each tick.
  - Drop night_mode -> AR_NS, tr 1, lamps 100/100.
- rst and tick in the same cycle during NS_Y:
  - rst wins; state AR_NS, tr 1, ped_pending 0.
